call_initiator: RTL

CALL_INITIATOR -- requirements
Module: call_initiator

---
 rtl/call_pkg.sv | 21 ++
 rtl/call_res_fifo.sv | 60 ++++++
 rtl/call_initiator.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/call_pkg.sv
// Shared types for the call initiator: FSM states, result entry and defaults.
// CALL_TIMEOUT_EN (see call_initiator) adds the wait-timeout abort path.
package call_pkg;

    localparam int CALL_DW                = 32;
    localparam int CALL_TIMEOUT_DEFAULT   = 1024;
    localparam int CALL_RES_DEPTH_DEFAULT = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } call_state_t;

    // One buffered call result; err marks a timed-out call with data forced to 0.
    typedef struct packed {
        logic               err;
        logic [CALL_DW-1:0] data;
    } call_res_t;

endpackage

// File: rtl/call_res_fifo.sv
// Result buffer between the call FSM and the downstream consumer.
// Synchronous FIFO of DEPTH entries (power of two); head is shown combinationally.
module call_res_fifo
    import call_pkg::*;
#(
    parameter int DEPTH = CALL_RES_DEPTH_DEFAULT
)(
    input  logic      __clk,
    input  logic      __resetn,
    input  logic      push,
    input  call_res_t push_data,
    input  logic      pop,
    output call_res_t head,
    output logic      full,
    output logic      empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    call_res_t     mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push against a full buffer is still safe.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge __clk or negedge __resetn) begin
        if (!__resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

endmodule

// File: rtl/call_initiator.sv
// Issues one call at a time to a start/idle/valid callee and buffers results.
// Define CALL_TIMEOUT_EN to abort a call after TIMEOUT cycles in S_WAIT.
//
// state   | meaning
// S_IDLE  | accept a request when the result buffer has room
// S_ISSUE | hold argument, pulse callee_start once the callee is idle
// S_WAIT  | wait for callee_valid (or timeout), push result, count the call
module call_initiator
    import call_pkg::*;
#(
    parameter int DW        = CALL_DW,
    parameter int TIMEOUT   = CALL_TIMEOUT_DEFAULT,
    parameter int RES_DEPTH = CALL_RES_DEPTH_DEFAULT
)(
    input  logic          __clk,
    input  logic          __resetn,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [DW-1:0] req_arg,
    output logic          callee_start,
    output logic [DW-1:0] callee_arg,
    input  logic          callee_idle,
    input  logic          callee_valid,
    input  logic [DW-1:0] callee_retval,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [DW-1:0] res_data,
    output logic          res_err,
    output logic          busy,
    output logic [15:0]   call_count
);

    call_state_t   state_q;
    call_state_t   state_d;
    logic [DW-1:0] arg_q;
    logic [15:0]   call_count_q;
    logic          ready_en_q;
    logic          load_arg;
    logic          push;
    call_res_t     push_entry;
    call_res_t     head;
    logic          fifo_full;
    logic          fifo_empty;

`ifdef CALL_TIMEOUT_EN
    localparam int WCW = $clog2(TIMEOUT);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

    logic [WCW-1:0] wait_cnt_q;
`endif

    always_comb begin
        state_d      = state_q;
        req_ready    = 1'b0;
        callee_start = 1'b0;
        load_arg     = 1'b0;
        push         = 1'b0;
        push_entry   = '0;
        case (state_q)
            S_IDLE: begin
                // ready_en_q keeps req_ready low until the first edge after reset release.
                req_ready = ready_en_q && !fifo_full;
                if (req_valid && req_ready) begin
                    load_arg = 1'b1;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                callee_start = callee_idle;
                if (callee_idle) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (callee_valid) begin
                    push            = 1'b1;
                    push_entry.data = callee_retval;
                    state_d         = S_IDLE;
                end
`ifdef CALL_TIMEOUT_EN
                else if (wait_cnt_q == WAIT_LAST) begin
                    push           = 1'b1;
                    push_entry.err = 1'b1;
                    state_d        = S_IDLE;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge __clk or negedge __resetn) begin
        if (!__resetn) begin
            state_q      <= S_IDLE;
            arg_q        <= '0;
            call_count_q <= '0;
            ready_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ready_en_q <= 1'b1;
            if (load_arg) begin
                arg_q <= req_arg;
            end
            if (push) begin
                call_count_q <= call_count_q + 16'd1;
            end
        end
    end

`ifdef CALL_TIMEOUT_EN
    // Held at zero outside S_WAIT, so it is always zero on the first waiting cycle.
    always_ff @(posedge __clk or negedge __resetn) begin
        if (!__resetn) begin
            wait_cnt_q <= '0;
        end else if (state_q != S_WAIT) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
        end
    end
`endif

    call_res_fifo #(
        .DEPTH (RES_DEPTH)
    ) u_res_fifo (
        .__clk     (__clk),
        .__resetn  (__resetn),
        .push      (push),
        .push_data (push_entry),
        .pop       (res_ready),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign callee_arg = arg_q;
    assign busy       = (state_q != S_IDLE);
    assign call_count = call_count_q;
    assign res_valid  = !fifo_empty;
    assign res_data   = head.data;

`ifdef CALL_TIMEOUT_EN
    assign res_err = head.err;
`else
    assign res_err = 1'b0;
`endif

endmodule
